// File: rtl/alu_pkg.sv
// Shared ALU definitions: reduction FSM states and flag bit positions.
package alu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } red_state_e;

  // Bit positions of the V/Z/N flags, shared with the ALU flag register.
  localparam int unsigned RedFlagV    = 0;
  localparam int unsigned RedFlagZ    = 1;
  localparam int unsigned RedFlagN    = 2;
  localparam int unsigned RedNumFlags = 3;

endpackage

// File: rtl/red_lane_sum.sv
// Combinational sum of LANES lane pairs, each extended to ACC_W per mode.
module red_lane_sum
  import alu_pkg::*;
#(
  parameter int unsigned LANE_W = 8,
  parameter int unsigned LANES  = 1,
  parameter int unsigned ACC_W  = 11
) (
  input  logic [LANES*LANE_W-1:0] a,
  input  logic [LANES*LANE_W-1:0] b,
  input  logic                    signed_md,
  output logic [ACC_W-1:0]        sum
);

  function automatic logic [ACC_W-1:0] ext_lane(input logic [LANE_W-1:0] v, input logic md);
    return {{(ACC_W - LANE_W){md & v[LANE_W-1]}}, v};
  endfunction

  // Add every extended lane of both operands; ACC_W is wide enough that this never wraps.
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + ext_lane(a[i*LANE_W +: LANE_W], signed_md)
                + ext_lane(b[i*LANE_W +: LANE_W], signed_md);
    end
  end

endmodule

// File: rtl/alu_red_seq.sv
// Multi-cycle lane-sum reduction with valid/ready handshakes and V/Z/N flags.
module alu_red_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned LANE_W        = 8,
  parameter int unsigned RES_W         = 16,
  parameter int unsigned LANES_PER_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              signed_md,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  result,
  output logic              ovfl,
  output logic              zero,
  output logic              sign
);

  localparam int unsigned NUM_LANES = DATA_W / LANE_W;
  localparam int unsigned ACC_W     = LANE_W + $clog2(2 * NUM_LANES) + 1;
  localparam int unsigned STEPS     = NUM_LANES / LANES_PER_CYC;
  localparam int unsigned CNT_W     = $clog2(STEPS + 1);
  localparam int unsigned SLICE_W   = LANES_PER_CYC * LANE_W;
  // One bit wider than both sum and result so range checks see a true sign bit.
  localparam int unsigned WIDE_W    = ((ACC_W > RES_W) ? ACC_W : RES_W) + 1;

  red_state_e             state_q, state_d;
  logic [DATA_W-1:0]      a_q, a_d;
  logic [DATA_W-1:0]      b_q, b_d;
  logic                   md_q, md_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RES_W-1:0]       result_q, result_d;
  logic [RedNumFlags-1:0] flags_q, flags_d;

  logic [ACC_W-1:0]       partial;
  logic [WIDE_W-1:0]      wide;
  logic                   range_ovf;

  // Operands are shifted down each step, so the adder always sees the low slice.
  red_lane_sum #(
    .LANE_W (LANE_W),
    .LANES  (LANES_PER_CYC),
    .ACC_W  (ACC_W)
  ) u_lane_sum (
    .a         (a_q[SLICE_W-1:0]),
    .b         (b_q[SLICE_W-1:0]),
    .signed_md (md_q),
    .sum       (partial)
  );

  // Extend the exact sum and test whether it fits the signed/unsigned RES_W range.
  always_comb begin
    wide = {{(WIDE_W - ACC_W){md_q & acc_q[ACC_W-1]}}, acc_q};
    if (md_q) begin
      range_ovf = !((&wide[WIDE_W-1:RES_W-1]) || !(|wide[WIDE_W-1:RES_W-1]));
    end else begin
      range_ovf = |wide[WIDE_W-1:RES_W];
    end
  end

  // FSM next state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    md_d      = md_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    flags_d   = flags_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          md_d    = signed_md;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (cnt_q == CNT_W'(STEPS)) begin
          // Accumulation complete: register result and flags together.
          result_d          = wide[RES_W-1:0];
          flags_d[RedFlagV] = range_ovf;
          flags_d[RedFlagZ] = (wide[RES_W-1:0] == '0);
          flags_d[RedFlagN] = wide[RES_W-1];
          state_d           = StDone;
        end else begin
          acc_d = acc_q + partial;
          a_d   = a_q >> SLICE_W;
          b_d   = b_q >> SLICE_W;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      md_q     <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      md_q     <= md_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result = result_q;
  assign ovfl   = flags_q[RedFlagV];
  assign zero   = flags_q[RedFlagZ];
  assign sign   = flags_q[RedFlagN];

endmodule

// File: tb/tb_alu_red_seq.sv
// Self-checking bench: default build, RES_W=8 build and LANES_PER_CYC=2 build run in lockstep.
module tb_alu_red_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, signed_md, out_ready;
  logic [15:0] a, b;

  logic        ir_d, ov_d, v_d, z_d, n_d;
  logic [15:0] res_d;
  logic        ir_n, ov_n, v_n, z_n, n_n;
  logic [7:0]  res_n;
  logic        ir_p, ov_p, v_p, z_p, n_p;
  logic [15:0] res_p;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  alu_red_seq u_dut (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (ir_d),
    .a (a), .b (b), .signed_md (signed_md), .out_valid (ov_d), .out_ready (out_ready),
    .result (res_d), .ovfl (v_d), .zero (z_d), .sign (n_d)
  );

  alu_red_seq #(.RES_W (8)) u_dut_narrow (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (ir_n),
    .a (a), .b (b), .signed_md (signed_md), .out_valid (ov_n), .out_ready (out_ready),
    .result (res_n), .ovfl (v_n), .zero (z_n), .sign (n_n)
  );

  alu_red_seq #(.LANES_PER_CYC (2)) u_dut_pair (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (ir_p),
    .a (a), .b (b), .signed_md (signed_md), .out_valid (ov_p), .out_ready (out_ready),
    .result (res_p), .ovfl (v_p), .zero (z_p), .sign (n_p)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Exact arithmetic sum of all byte lanes of x and y.
  function automatic int lane_sum(input logic [15:0] x, input logic [15:0] y, input logic md);
    int s = 0;
    for (int i = 0; i < 2; i++) begin
      int la = int'((x >> (8 * i)) & 16'hFF);
      int lb = int'((y >> (8 * i)) & 16'hFF);
      if (md && la > 127) la -= 256;
      if (md && lb > 127) lb -= 256;
      s += la + lb;
    end
    return s;
  endfunction

  function automatic logic [15:0] model_res(input int s, input int rw);
    logic [15:0] r = 16'(s);
    if (rw < 16) r = r & 16'((32'd1 << rw) - 1);
    return r;
  endfunction

  function automatic logic model_v(input int s, input logic md, input int rw);
    if (md) return (s < -(1 << (rw - 1))) || (s > (1 << (rw - 1)) - 1);
    return s > (1 << rw) - 1;
  endfunction

  task automatic check_res(input string tag, input logic [15:0] r, input logic v, input logic z,
                           input logic n, input int s, input logic md, input int rw);
    logic [15:0] er = model_res(s, rw);
    check_eq({tag, "/result"}, 32'(r), 32'(er));
    check_eq({tag, "/V"}, 32'(v), 32'(model_v(s, md, rw)));
    check_eq({tag, "/Z"}, 32'(z), 32'(er == 16'h0));
    check_eq({tag, "/N"}, 32'(n), 32'(er[rw-1]));
  endtask

  // One operation with out_ready held high; checks latency and result on all three builds.
  task automatic run_op(input string tag, input logic [15:0] ai, input logic [15:0] bi,
                        input logic md);
    int s, lat_d, lat_n, lat_p;
    s = lane_sum(ai, bi, md);
    lat_d = -1; lat_n = -1; lat_p = -1;
    @(negedge clk);
    a = ai; b = bi; signed_md = md; in_valid = 1'b1;
    check_eq({tag, "/in_ready"}, 32'({ir_d, ir_n, ir_p}), 32'b111);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); signed_md = ~md;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (ov_d && lat_d < 0) begin
        lat_d = c;
        check_res({tag, "/d"}, res_d, v_d, z_d, n_d, s, md, 16);
      end
      if (ov_n && lat_n < 0) begin
        lat_n = c;
        check_res({tag, "/n"}, {8'h0, res_n}, v_n, z_n, n_n, s, md, 8);
      end
      if (ov_p && lat_p < 0) begin
        lat_p = c;
        check_res({tag, "/p"}, res_p, v_p, z_p, n_p, s, md, 16);
      end
    end
    check_eq({tag, "/lat_d"}, 32'(lat_d), 32'd3);
    check_eq({tag, "/lat_n"}, 32'(lat_n), 32'd3);
    check_eq({tag, "/lat_p"}, 32'(lat_p), 32'd2);
  endtask

  initial begin
    int waited;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; signed_md = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset/handshake", 32'({ir_d, ov_d, ir_n, ov_n, ir_p, ov_p}), 32'b101010);
    check_eq("reset/result", 32'({res_d, res_n}), 32'h0);
    check_eq("reset/flags", 32'({v_d, z_d, n_d, v_n, z_n, n_n, v_p, z_p, n_p}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("t1_unsigned", 16'h0102, 16'h0304, 1'b0);
    run_op("t2_ff_unsigned", 16'hFFFF, 16'hFFFF, 1'b0);
    run_op("t2_ff_signed", 16'hFFFF, 16'hFFFF, 1'b1);
    run_op("t3_zero", 16'h0000, 16'h0000, 1'b0);
    run_op("t3_cancel", 16'h01FF, 16'h0000, 1'b1);
    run_op("t4_min_signed", 16'h8080, 16'h8080, 1'b1);
    run_op("max_signed", 16'h7F7F, 16'h7F7F, 1'b1);
    for (int i = 0; i < 30; i++) begin
      run_op("random", 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    // Back-pressure: hold DONE, offer a competing request, then release.
    out_ready = 1'b0;
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; signed_md = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waited = 0;
    while (!ov_d && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq("bp/latency", 32'(waited), 32'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; signed_md = 1'b1;
      @(posedge clk); #1;
      check_eq("bp/out_valid", 32'(ov_d), 32'd1);
      check_eq("bp/in_ready", 32'({ir_d, ir_n, ir_p}), 32'b000);
      check_eq("bp/result", 32'(res_d), 32'h114);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp/release_idle", 32'({ir_d, ov_d, ir_n, ov_n, ir_p, ov_p}), 32'b101010);
    run_op("after_bp", 16'h0102, 16'h0304, 1'b0);

    // Reset one cycle into accumulation aborts the operation.
    @(negedge clk);
    a = 16'h7777; b = 16'h1111; signed_md = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("abort/handshake", 32'({ir_d, ov_d, ir_n, ov_n, ir_p, ov_p}), 32'b101010);
    check_eq("abort/result", 32'(res_d), 32'h0);
    check_eq("abort/result_p", 32'(res_p), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_abort", 16'h80FF, 16'h017F, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
